cbrt_dispatch: RTL and testbench

//   Front-end sequencer for the cbrt core. Queues 8-bit operands from a valid/ready

---
 rtl/cbrt_dispatch.sv | 153 +++++++++++++++
 tb/tb_cbrt_dispatch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbrt_dispatch.sv
// Front-end sequencer for the cbrt core: queues operands, runs the core one at a time
// (reset pulse, start pulse, wait for busy to fall) and returns root, cycle count and timeout.
module cbrt_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2000,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_x,
    output logic          core_rst_o,
    output logic          core_start_o,
    output logic [7:0]    core_x_o,
    input  logic          core_busy_i,
    input  logic [2:0]    core_result_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_x,
    output logic [2:0]    out_root,
    output logic          out_timeout,
    output logic [CW-1:0] out_cycles
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GAP,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state, state_d;
    logic [7:0]         mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               push, pop;
    logic [7:0]         x_reg;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic               seen_busy;
    logic               timed_out, done;

    assign in_ready     = (count != (AW + 1)'(DEPTH));
    assign push         = in_valid && in_ready;
    assign cnt_inc      = cnt + CNT_W'(1);
    assign timed_out    = (cnt_inc == CNT_W'(TIMEOUT));
    assign done         = seen_busy && !core_busy_i;
    assign core_start_o = (state == S_START);
    assign out_valid    = (state == S_HOLD);
    assign core_x_o     = x_reg;
    assign out_x        = x_reg;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_d = S_CLR;
                    pop     = 1'b1;
                end
            end
            S_CLR:   state_d = S_GAP;
            S_GAP:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (timed_out || done) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (count != '0) begin
                        state_d = S_CLR;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            core_rst_o <= 1'b1;
        end else begin
            state      <= state_d;
            core_rst_o <= (state_d == S_CLR);
        end
    end

    // NOTE: the storage array holds no control state, so it is left out of reset; count guards every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_x;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            x_reg  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                x_reg  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Timeout wins over completion when both land in the same WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            seen_busy   <= 1'b0;
            out_root    <= '0;
            out_timeout <= 1'b0;
            out_cycles  <= '0;
        end else if (state == S_START) begin
            cnt         <= '0;
            seen_busy   <= 1'b0;
            out_root    <= '0;
            out_timeout <= 1'b0;
            out_cycles  <= '0;
        end else if (state == S_WAIT) begin
            cnt       <= cnt_inc;
            seen_busy <= seen_busy || core_busy_i;
            if (core_busy_i && (out_cycles != {CW{1'b1}}))
                out_cycles <= out_cycles + CW'(1);
            if (timed_out) begin
                out_timeout <= 1'b1;
                out_root    <= '0;
            end else if (done) begin
                out_root    <= core_result_i;
            end
        end
    end

endmodule

// File: tb/tb_cbrt_dispatch.sv
// Directed bench for cbrt_dispatch with a behavioural cbrt stub (5 busy cycles, optional stuck busy).
module tb_cbrt_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic        core_rst_o, core_start_o;
    logic [7:0]  core_x_o;
    logic        core_busy_i;
    logic [2:0]  core_result_i;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_x;
    logic [2:0]  out_root;
    logic        out_timeout;
    logic [15:0] out_cycles;

    int errors = 0;
    int checks = 0;

    cbrt_dispatch #(.DEPTH(4), .TIMEOUT(16), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .core_rst_o(core_rst_o), .core_start_o(core_start_o), .core_x_o(core_x_o),
        .core_busy_i(core_busy_i), .core_result_i(core_result_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
        .out_root(out_root), .out_timeout(out_timeout), .out_cycles(out_cycles)
    );

    always #5 clk = ~clk;

    // Stub core: busy for 5 cycles after start, result ready when busy falls.
    logic       stub_stuck = 1'b0;
    logic [3:0] stub_cnt;

    function automatic logic [2:0] cbrt_of(input logic [7:0] x);
        logic [2:0] r = 3'd0;
        for (int k = 1; k <= 6; k++)
            if (k * k * k <= int'(x)) r = 3'(k);
        return r;
    endfunction

    always @(posedge clk) begin
        if (core_rst_o) begin
            core_busy_i   <= 1'b0;
            stub_cnt      <= '0;
            core_result_i <= '0;
        end else if (core_start_o) begin
            core_busy_i   <= 1'b1;
            stub_cnt      <= 4'd5;
            core_result_i <= cbrt_of(core_x_o);
        end else if (core_busy_i && !stub_stuck) begin
            if (stub_cnt == 4'd1) core_busy_i <= 1'b0;
            stub_cnt <= stub_cnt - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!core_start_o && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(core_start_o), 32'd1);
    endtask

    initial begin
        logic [7:0] xs2 [5];
        logic [2:0] rs2 [5];
        logic [7:0] xs3 [6];
        logic [2:0] rs3 [6];
        logic [7:0] hold_x;
        logic [2:0] hold_root;
        int acc;
        int n;
        xs2 = '{8'd27, 8'd64, 8'd125, 8'd216, 8'd8};
        rs2 = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd2};
        xs3 = '{8'd1, 8'd8, 8'd27, 8'd64, 8'd125, 8'd216};
        rs3 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

        // Reset state
        tick();
        tick();
        check("rst_core_rst", 32'(core_rst_o), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_start", 32'(core_start_o), 32'd0);
        check("rst_core_x", 32'(core_x_o), 32'd0);
        check("rst_out_root", 32'(out_root), 32'd0);
        check("rst_out_timeout", 32'(out_timeout), 32'd0);
        check("rst_out_cycles", 32'(out_cycles), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_core_rst", 32'(core_rst_o), 32'd0);

        // 1: single operand, pulse ordering and latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'd27;
        tick();
        in_valid = 1'b0;
        check("t1_n_rst", 32'(core_rst_o), 32'd0);
        check("t1_n_start", 32'(core_start_o), 32'd0);
        tick();
        check("t1_clr_rst", 32'(core_rst_o), 32'd1);
        check("t1_clr_start", 32'(core_start_o), 32'd0);
        check("t1_clr_x", 32'(core_x_o), 32'd27);
        tick();
        check("t1_gap_rst", 32'(core_rst_o), 32'd0);
        check("t1_gap_start", 32'(core_start_o), 32'd0);
        tick();
        check("t1_start_start", 32'(core_start_o), 32'd1);
        check("t1_start_rst", 32'(core_rst_o), 32'd0);
        tick();
        check("t1_wait_start", 32'(core_start_o), 32'd0);
        check("t1_wait_x", 32'(core_x_o), 32'd27);
        wait_valid("t1");
        check("t1_x", 32'(out_x), 32'd27);
        check("t1_root", 32'(out_root), 32'd3);
        check("t1_timeout", 32'(out_timeout), 32'd0);
        check("t1_cycles", 32'(out_cycles), 32'd5);
        tick();
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // 2: back-to-back operands
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = xs2[i];
            check("t2_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_valid("t2");
            check("t2_x", 32'(out_x), 32'(xs2[i]));
            check("t2_root", 32'(out_root), 32'(rs2[i]));
            tick();
        end

        // 3: back-pressure, capacity DEPTH + 1
        while (out_valid) tick();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_x     = xs3[i];
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("t3_accepted", 32'(acc), 32'd5);
        check("t3_full", 32'(in_ready), 32'd0);

        // 4: HOLD stall keeps outputs stable and issues no start
        wait_valid("t4");
        hold_x    = out_x;
        hold_root = out_root;
        check("t4_first_x", 32'(hold_x), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_valid", 32'(out_valid), 32'd1);
            check("t4_x", 32'(out_x), 32'(hold_x));
            check("t4_root", 32'(out_root), 32'(hold_root));
            check("t4_start", 32'(core_start_o), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid("t3");
            check("t3_x", 32'(out_x), 32'(xs3[i]));
            check("t3_root", 32'(out_root), 32'(rs3[i]));
            tick();
        end
        check("t3_drained", 32'(in_ready), 32'd1);

        // 5: stuck core times out after 16 WAIT cycles
        stub_stuck = 1'b1;
        in_valid   = 1'b1;
        in_x       = 8'd100;
        tick();
        in_valid = 1'b0;
        wait_start("t5");
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("t5_wait_len", 32'(n), 32'd17);
        check("t5_timeout", 32'(out_timeout), 32'd1);
        check("t5_root", 32'(out_root), 32'd0);
        check("t5_cycles", 32'(out_cycles), 32'd16);
        check("t5_x", 32'(out_x), 32'd100);
        tick();
        stub_stuck = 1'b0;

        // 6: asynchronous reset mid-WAIT, then normal operation
        in_valid = 1'b1;
        in_x     = 8'd27;
        tick();
        in_valid = 1'b0;
        wait_start("t6");
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t6_core_rst", 32'(core_rst_o), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_start", 32'(core_start_o), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_idle_rst", 32'(core_rst_o), 32'd0);
        check("t6_idle_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_x     = 8'd64;
        tick();
        in_valid = 1'b0;
        wait_valid("t6");
        check("t6_x", 32'(out_x), 32'd64);
        check("t6_root", 32'(out_root), 32'd4);
        check("t6_timeout", 32'(out_timeout), 32'd0);
        tick();
        check("t6_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
